id_ex_stage: RTL and testbench

ID/EX pipeline register and operand-selection stage that sits directly upstream of the ALU. It captures decoded instructions and register-file read values, and detects load-use hazards so it can stall decode and insert bubbles. In the EX cycle it forwards EX/MEM and MEM/WB results onto the ALU a/b operands. It also supports flush on redirect and a hold from downstream stalls.

---
 rtl/id_ex_stage.sv | 172 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold control,
// and EX/MEM, MEM/WB operand forwarding onto the ALU inputs.
module id_ex_stage #(
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 32,
    parameter int FUNC_W     = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [DATA_W-1:0]     id_rs_val,
    input  logic [DATA_W-1:0]     id_rt_val,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic                  id_use_imm,
    input  logic [FUNC_W-1:0]     id_func,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  flush_i,
    input  logic                  stall_i,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [DATA_W-1:0]     exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [DATA_W-1:0]     memwb_result,
    output logic                  id_stall,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    output logic [FUNC_W-1:0]     ex_func,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic [DATA_W-1:0]     ex_store_data
);

    logic                  valid_q,    valid_d;
    logic [REG_ADDR_W-1:0] rs_q,       rs_d;
    logic [REG_ADDR_W-1:0] rt_q,       rt_d;
    logic [REG_ADDR_W-1:0] rd_q,       rd_d;
    logic [DATA_W-1:0]     rsVal_q,    rsVal_d;
    logic [DATA_W-1:0]     rtVal_q,    rtVal_d;
    logic [DATA_W-1:0]     imm_q,      imm_d;
    logic                  useImm_q,   useImm_d;
    logic [FUNC_W-1:0]     func_q,     func_d;
    logic                  regWrite_q, regWrite_d;
    logic                  memRead_q,  memRead_d;
    logic                  memWrite_q, memWrite_d;

    logic                  loadUse;
    logic [DATA_W-1:0]     fwdRs;
    logic [DATA_W-1:0]     fwdRt;

    // A store needs its rt data even when b comes from the immediate.
    always_comb begin
        loadUse = valid_q & memRead_q & (rd_q != '0) & id_valid &
                  ((rd_q == id_rs) |
                   ((rd_q == id_rt) & (~id_use_imm | id_mem_write)));
        id_stall = loadUse | stall_i;
    end

    always_comb begin
        valid_d    = valid_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        rsVal_d    = rsVal_q;
        rtVal_d    = rtVal_q;
        imm_d      = imm_q;
        useImm_d   = useImm_q;
        func_d     = func_q;
        regWrite_d = regWrite_q;
        memRead_d  = memRead_q;
        memWrite_d = memWrite_q;
        if (stall_i) begin
            // Hold; a redirect arriving during a hold must be reasserted.
        end else if (flush_i || loadUse) begin
            valid_d    = 1'b0;
            rs_d       = '0;
            rt_d       = '0;
            rd_d       = '0;
            rsVal_d    = '0;
            rtVal_d    = '0;
            imm_d      = '0;
            useImm_d   = 1'b0;
            func_d     = '0;
            regWrite_d = 1'b0;
            memRead_d  = 1'b0;
            memWrite_d = 1'b0;
        end else begin
            valid_d    = id_valid;
            rs_d       = id_rs;
            rt_d       = id_rt;
            rd_d       = id_rd;
            rsVal_d    = id_rs_val;
            rtVal_d    = id_rt_val;
            imm_d      = id_imm;
            useImm_d   = id_use_imm;
            func_d     = id_func;
            regWrite_d = id_reg_write & id_valid;
            memRead_d  = id_mem_read  & id_valid;
            memWrite_d = id_mem_write & id_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            rsVal_q    <= '0;
            rtVal_q    <= '0;
            imm_q      <= '0;
            useImm_q   <= 1'b0;
            func_q     <= '0;
            regWrite_q <= 1'b0;
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            rsVal_q    <= rsVal_d;
            rtVal_q    <= rtVal_d;
            imm_q      <= imm_d;
            useImm_q   <= useImm_d;
            func_q     <= func_d;
            regWrite_q <= regWrite_d;
            memRead_q  <= memRead_d;
            memWrite_q <= memWrite_d;
        end
    end

    // EX/MEM is the younger result, so it wins over MEM/WB; r0 is never forwarded.
    always_comb begin
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_q)) begin
            fwdRs = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_q)) begin
            fwdRs = memwb_result;
        end else begin
            fwdRs = rsVal_q;
        end

        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rt_q)) begin
            fwdRt = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_q)) begin
            fwdRt = memwb_result;
        end else begin
            fwdRt = rtVal_q;
        end
    end

    always_comb begin
        ex_valid      = valid_q;
        ex_func       = func_q;
        ex_rd         = rd_q;
        ex_reg_write  = valid_q & regWrite_q;
        ex_mem_read   = valid_q & memRead_q;
        ex_mem_write  = valid_q & memWrite_q;
        alu_a         = fwdRs;
        alu_b         = useImm_q ? imm_q : fwdRt;
        ex_store_data = fwdRt;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: reset, capture, forwarding,
// load-use stalls, immediate operands, and flush/stall interactions.
module tb_id_ex_stage;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int FUNC_W     = 6;

    logic                  clk;
    logic                  rst_n;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs, id_rt, id_rd;
    logic [DATA_W-1:0]     id_rs_val, id_rt_val, id_imm;
    logic                  id_use_imm;
    logic [FUNC_W-1:0]     id_func;
    logic                  id_reg_write, id_mem_read, id_mem_write;
    logic                  flush_i, stall_i;
    logic                  exmem_reg_write;
    logic [REG_ADDR_W-1:0] exmem_rd;
    logic [DATA_W-1:0]     exmem_result;
    logic                  memwb_reg_write;
    logic [REG_ADDR_W-1:0] memwb_rd;
    logic [DATA_W-1:0]     memwb_result;
    logic                  id_stall, ex_valid;
    logic [DATA_W-1:0]     alu_a, alu_b, ex_store_data;
    logic [FUNC_W-1:0]     ex_func;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_reg_write, ex_mem_read, ex_mem_write;

    int checkCount = 0;
    int errorCount = 0;

    id_ex_stage #(
        .REG_ADDR_W(REG_ADDR_W),
        .DATA_W    (DATA_W),
        .FUNC_W    (FUNC_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rd          (id_rd),
        .id_rs_val      (id_rs_val),
        .id_rt_val      (id_rt_val),
        .id_imm         (id_imm),
        .id_use_imm     (id_use_imm),
        .id_func        (id_func),
        .id_reg_write   (id_reg_write),
        .id_mem_read    (id_mem_read),
        .id_mem_write   (id_mem_write),
        .flush_i        (flush_i),
        .stall_i        (stall_i),
        .exmem_reg_write(exmem_reg_write),
        .exmem_rd       (exmem_rd),
        .exmem_result   (exmem_result),
        .memwb_reg_write(memwb_reg_write),
        .memwb_rd       (memwb_rd),
        .memwb_result   (memwb_result),
        .id_stall       (id_stall),
        .ex_valid       (ex_valid),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .ex_func        (ex_func),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_store_data  (ex_store_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU, used to confirm the operands produce the intended result.
    function automatic logic [DATA_W-1:0] aluRef(input logic [FUNC_W-1:0] f,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        case (f)
            6'd0:    return a + b;
            6'd1:    return a - b;
            6'd2:    return a & b;
            6'd3:    return a | b;
            6'd4:    return {31'b0, $signed(a) < $signed(b)};
            6'd5:    return a * b;
            default: return '0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                               input logic [DATA_W-1:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            errorCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [31:0] rsVal,
                                 input logic [31:0] rtVal, input logic [31:0] imm,
                                 input logic useImm, input logic [5:0] func,
                                 input logic rw, input logic mr, input logic mw);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_rd        = rd;
        id_rs_val    = rsVal;
        id_rt_val    = rtVal;
        id_imm       = imm;
        id_use_imm   = useImm;
        id_func      = func;
        id_reg_write = rw;
        id_mem_read  = mr;
        id_mem_write = mw;
    endtask

    task automatic setForward(input logic exW, input logic [4:0] exRd, input logic [31:0] exRes,
                              input logic wbW, input logic [4:0] wbRd, input logic [31:0] wbRes);
        exmem_reg_write = exW;
        exmem_rd        = exRd;
        exmem_result    = exRes;
        memwb_reg_write = wbW;
        memwb_rd        = wbRd;
        memwb_result    = wbRes;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        flush_i = 1'b0;
        stall_i = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        setForward(0, 0, 0, 0, 0, 0);
        #12;
        checkOutput("rst_ex_valid", {31'b0, ex_valid}, 0);
        checkOutput("rst_ex_func", {26'b0, ex_func}, 0);
        checkOutput("rst_id_stall", {31'b0, id_stall}, 0);
        checkOutput("rst_alu_a", alu_a, 0);
        checkOutput("rst_alu_b", alu_b, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] independent ADD");
        applyStimulus(1, 1, 2, 5, 32'd5, 32'd7, 0, 0, 6'd0, 1, 0, 0);
        stepCycle();
        checkOutput("add_ex_valid", {31'b0, ex_valid}, 1);
        checkOutput("add_alu_a", alu_a, 32'd5);
        checkOutput("add_alu_b", alu_b, 32'd7);
        checkOutput("add_ex_func", {26'b0, ex_func}, 0);
        checkOutput("add_ex_rd", {27'b0, ex_rd}, 5);
        checkOutput("add_ex_reg_write", {31'b0, ex_reg_write}, 1);
        checkOutput("add_alu_result", aluRef(ex_func, alu_a, alu_b), 32'd12);

        $display("[TB] forwarding");
        applyStimulus(1, 3, 6, 7, 32'd0, 32'h33, 0, 0, 6'd1, 1, 0, 0);
        stepCycle();
        setForward(1, 3, 32'h10, 1, 3, 32'h20);
        #1 checkOutput("fwd_exmem_prio", alu_a, 32'h10);
        exmem_reg_write = 1'b0;
        #1 checkOutput("fwd_memwb", alu_a, 32'h20);
        setForward(1, 0, 32'hFF, 0, 3, 32'h20);
        #1 checkOutput("fwd_r0_ignored", alu_a, 32'h0);
        setForward(0, 0, 0, 1, 6, 32'h66);
        #1 checkOutput("fwd_rt_alu_b", alu_b, 32'h66);
        checkOutput("fwd_rt_store", ex_store_data, 32'h66);
        setForward(0, 0, 0, 0, 0, 0);

        $display("[TB] load-use");
        applyStimulus(1, 0, 0, 4, 0, 0, 0, 0, 6'd0, 1, 1, 0);
        stepCycle();
        checkOutput("lw_ex_mem_read", {31'b0, ex_mem_read}, 1);
        applyStimulus(1, 4, 7, 8, 32'd0, 32'd3, 0, 0, 6'd1, 1, 0, 0);
        #1 checkOutput("lu_id_stall", {31'b0, id_stall}, 1);
        stepCycle();
        checkOutput("lu_bubble_valid", {31'b0, ex_valid}, 0);
        checkOutput("lu_bubble_mem_read", {31'b0, ex_mem_read}, 0);
        checkOutput("lu_bubble_reg_write", {31'b0, ex_reg_write}, 0);
        checkOutput("lu_stall_released", {31'b0, id_stall}, 0);
        stepCycle();
        setForward(1, 4, 32'd9, 0, 0, 0);
        #1 checkOutput("lu_sub_valid", {31'b0, ex_valid}, 1);
        checkOutput("lu_sub_func", {26'b0, ex_func}, 1);
        checkOutput("lu_sub_alu_a", alu_a, 32'd9);
        checkOutput("lu_sub_alu_b", alu_b, 32'd3);

        $display("[TB] immediate operand");
        applyStimulus(1, 0, 4, 9, 32'd0, 32'd1, 32'hFFFF_FFFE, 1, 6'd0, 1, 0, 0);
        stepCycle();
        checkOutput("imm_alu_b", alu_b, 32'hFFFF_FFFE);
        checkOutput("imm_store_data", ex_store_data, 32'd9);
        checkOutput("imm_alu_a", alu_a, 32'd0);
        setForward(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 10, 0, 0, 0, 0, 6'd0, 1, 1, 0);
        stepCycle();
        applyStimulus(1, 0, 10, 11, 0, 0, 32'd4, 1, 6'd0, 1, 0, 0);
        #1 checkOutput("imm_rt_no_stall", {31'b0, id_stall}, 0);
        applyStimulus(1, 0, 10, 0, 0, 0, 32'd4, 1, 6'd0, 0, 0, 1);
        #1 checkOutput("store_rt_stall", {31'b0, id_stall}, 1);
        applyStimulus(1, 0, 10, 11, 0, 0, 0, 0, 6'd0, 1, 0, 0);
        #1 checkOutput("reg_rt_stall", {31'b0, id_stall}, 1);

        $display("[TB] flush and stall");
        flush_i = 1'b1;
        #1 checkOutput("flush_lu_id_stall", {31'b0, id_stall}, 1);
        stepCycle();
        checkOutput("flush_bubble_valid", {31'b0, ex_valid}, 0);
        flush_i = 1'b0;
        applyStimulus(1, 1, 0, 11, 32'h44, 0, 0, 0, 6'd3, 1, 0, 0);
        stepCycle();
        checkOutput("pre_hold_func", {26'b0, ex_func}, 3);
        applyStimulus(1, 1, 0, 12, 32'h55, 0, 0, 0, 6'd2, 1, 0, 0);
        stall_i = 1'b1;
        flush_i = 1'b1;
        #1 checkOutput("hold_id_stall", {31'b0, id_stall}, 1);
        stepCycle();
        checkOutput("hold_ex_valid", {31'b0, ex_valid}, 1);
        checkOutput("hold_ex_func", {26'b0, ex_func}, 3);
        checkOutput("hold_ex_rd", {27'b0, ex_rd}, 11);
        checkOutput("hold_alu_a", alu_a, 32'h44);
        checkOutput("hold_reg_write", {31'b0, ex_reg_write}, 1);

        $display("[TB] reset mid-stall");
        #1;
        stall_i = 1'b0;
        flush_i = 1'b0;
        rst_n   = 1'b0;
        #1 checkOutput("mid_rst_ex_valid", {31'b0, ex_valid}, 0);
        checkOutput("mid_rst_reg_write", {31'b0, ex_reg_write}, 0);
        checkOutput("mid_rst_ex_func", {26'b0, ex_func}, 0);
        checkOutput("mid_rst_id_stall", {31'b0, id_stall}, 0);
        checkOutput("mid_rst_alu_a", alu_a, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        stepCycle();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
